// File: rtl/dmem_axi_bridge.sv
// Bridges a simple req/addr_ok/data_ok data-memory port onto single-beat AXI reads and writes.
// Latency: a load with ready AXI slaves gives data_ok three cycles after the accept cycle.
// Backpressure: only one transaction is in flight; addr_ok stays low until the response cycle has passed.
module dmem_axi_bridge #(
  parameter logic [3:0] AXI_ID = 4'd1
) (
  input  logic        clk,
  input  logic        reset,
  // requester side
  input  logic        req,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  // AR channel
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  // R channel
  input  logic [31:0] r_data,
  input  logic        rvalid,
  output logic        rready,
  // AW channel
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  // W channel
  output logic [31:0] w_data,
  output logic [3:0]  w_strb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  // B channel
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    AR   = 3'd1,
    R    = 3'd2,
    W    = 3'd3,
    B    = 3'd4,
    RESP = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic [31:0] addr_q;
  logic        we_q;
  logic [1:0]  size_q;
  logic [3:0]  wstrb_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;

  // Next-state and handshake outputs; reset forces every valid/ready/ok low.
  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    addr_ok   = 1'b0;
    data_ok   = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    case (state_q)
      IDLE: begin
        addr_ok = req;
        if (req) begin
          state_d   = we ? W : AR;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      AR: begin
        arvalid = 1'b1;
        if (arready) state_d = R;
      end
      R: begin
        rready = 1'b1;
        if (rvalid) state_d = RESP;
      end
      W: begin
        // AW and W are independent; each drops once its own handshake is done.
        awvalid = !aw_done_q;
        wvalid  = !w_done_q;
        if (awvalid && awready) aw_done_d = 1'b1;
        if (wvalid && wready)   w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) state_d = B;
      end
      B: begin
        bready = 1'b1;
        if (bvalid) state_d = RESP;
      end
      RESP: begin
        data_ok = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (reset) begin
      addr_ok = 1'b0;
      data_ok = 1'b0;
      arvalid = 1'b0;
      rready  = 1'b0;
      awvalid = 1'b0;
      wvalid  = 1'b0;
      bready  = 1'b0;
    end
  end

  // State register and write-handshake flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Request payload is captured on the accept cycle and held for the whole transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= 32'd0;
      we_q    <= 1'b0;
      size_q  <= 2'd0;
      wstrb_q <= 4'd0;
      wdata_q <= 32'd0;
    end else if (addr_ok) begin
      addr_q  <= addr;
      we_q    <= we;
      size_q  <= size;
      wstrb_q <= wstrb;
      wdata_q <= wdata;
    end
  end

  // Load data is captured on the R handshake and held until the next load capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= 32'd0;
    end else if (state_q == R && rvalid && !we_q) begin
      rdata_q <= r_data;
    end
  end

  assign rdata  = rdata_q;
  assign arid   = AXI_ID;
  assign araddr = addr_q;
  assign arsize = {1'b0, size_q};
  assign awid   = AXI_ID;
  assign awaddr = addr_q;
  assign awsize = {1'b0, size_q};
  assign w_data = wdata_q;
  assign w_strb = wstrb_q;
  assign wlast  = wvalid;

endmodule
